ps2_kbd_queue: RTL and testbench

- Consumes the scancode byte stream from the PS/2 keyboard receiver (`scancode_sync` / `irq_sync` pair).
- Folds E0 (extended) and F0 (break) prefix bytes into single key events, and buffers events in a small FIFO.
- Exposes events to the CPU through a two-register 16-bit I/O slave, with a level interrupt while events are pending.

---
 rtl/ps2_kbd_pkg.sv | 19 +
 rtl/ps2_kbd_queue_fifo.sv | 39 +++
 rtl/ps2_kbd_queue.sv | 97 +++++++++
 tb/tb_ps2_kbd_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared encodings for the PS/2 keyboard event queue.
package ps2_kbd_pkg;
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;
    localparam int STAT_NE = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF = 2;
    localparam int STAT_IEN = 3;
    localparam int EV_VALID = 15;
    localparam int EV_EXT = 9;
    localparam int EV_REL = 8;
    localparam int EV_W = 10;
    function automatic logic [EV_W-1:0] mk_ev(input logic ext, input logic rel, input logic [7:0] code);
        return {ext, rel, code};
    endfunction
endpackage

// File: rtl/ps2_kbd_queue_fifo.sv
// kbd_fifo: synchronous FIFO with a combinational head; a push into a full FIFO
// only lands when a pop happens in the same cycle.
module kbd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr = push & (~full | pop);
    assign rd = pop & ~empty;
    assign head = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
endmodule

// File: rtl/ps2_kbd_queue.sv
// ps2_kbd_queue: folds E0/F0 scancode prefixes into key events, queues them,
// and exposes DATA/STATUS registers with a level interrupt.
module ps2_kbd_queue
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TO_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kbd_code,
    input  logic        kbd_irq,
    input  logic        reg_addr,
    input  logic        reg_rd,
    input  logic        reg_wr,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata,
    output logic        irq
);
    state_t state, state_n;
    logic irq_q, acc, push, pop, st_wr, full, empty, ovf, irq_en, timeout;
    logic [TO_W-1:0] to_cnt;
    logic [EV_W-1:0] ev, head;
    logic [$clog2(DEPTH):0] count;
    logic [15:0] status, data;
    logic unused_wdata;
    assign unused_wdata = ^{reg_wdata[15:4], reg_wdata[1:0]};
    assign acc = kbd_irq & ~irq_q;
    assign pop = reg_rd & (reg_addr == ADDR_DATA) & ~empty;
    assign st_wr = reg_wr & (reg_addr == ADDR_STATUS);
    assign timeout = state != S_IDLE && to_cnt == '1;
    kbd_fifo #(.WIDTH(EV_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(ev),
        .head(head), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge clk)
        state <= rst ? S_IDLE : state_n;
    always_comb begin
        state_n = state;
        push = 1'b0;
        ev = mk_ev(1'b0, 1'b0, kbd_code);
        if (acc && (kbd_code == 8'h00 || kbd_code == 8'hFF)) begin
            state_n = S_IDLE;
        end else if (acc) begin
            case (state)
                S_IDLE: begin
                    state_n = kbd_code == PFX_EXT ? S_EXT : kbd_code == PFX_BRK ? S_BRK : S_IDLE;
                    push = kbd_code != PFX_EXT && kbd_code != PFX_BRK;
                end
                S_EXT: begin
                    state_n = kbd_code == PFX_BRK ? S_EXT_BRK : kbd_code == PFX_EXT ? S_EXT : S_IDLE;
                    push = kbd_code != PFX_EXT && kbd_code != PFX_BRK;
                    ev = mk_ev(1'b1, 1'b0, kbd_code);
                end
                S_BRK: begin
                    state_n = S_IDLE;
                    push = 1'b1;
                    ev = mk_ev(1'b0, 1'b1, kbd_code);
                end
                default: begin
                    state_n = S_IDLE;
                    push = 1'b1;
                    ev = mk_ev(1'b1, 1'b1, kbd_code);
                end
            endcase
        end else if (timeout) begin
            state_n = S_IDLE;
        end
    end
    // The edge register tracks kbd_irq even in reset so a held pulse is never accepted.
    always_ff @(posedge clk) begin
        irq_q <= kbd_irq;
        if (rst) begin
            to_cnt <= '0;
            ovf <= 1'b0;
            irq_en <= 1'b0;
            irq <= 1'b0;
        end else begin
            to_cnt <= acc ? '0 : (state != S_IDLE && to_cnt != '1) ? to_cnt + 1'b1 : to_cnt;
            ovf <= (push & full & ~pop) | (ovf & ~(st_wr & reg_wdata[STAT_OVF]));
            if (st_wr) irq_en <= reg_wdata[STAT_IEN];
            irq <= irq_en & ~empty;
        end
    end
    always_comb begin
        status = '0;
        status[15:8] = 8'(count);
        status[STAT_NE] = ~empty;
        status[STAT_FULL] = full;
        status[STAT_OVF] = ovf;
        status[STAT_IEN] = irq_en;
        data = '0;
        data[EV_VALID] = ~empty;
        data[EV_W-1:0] = empty ? '0 : head;
        reg_rdata = reg_addr == ADDR_STATUS ? status : data;
    end
endmodule

// File: tb/tb_ps2_kbd_queue.sv
// tb_ps2_kbd_queue: scenario tasks plus a randomized byte stream, checked
// against a queue-based model of the prefix rules and register map.
module tb_ps2_kbd_queue;
    localparam int DEPTH = 8;
    localparam int TO_W = 6;
    logic clk = 0, rst = 0, kbd_irq = 0, reg_addr = 0, reg_rd = 0, reg_wr = 0, irq;
    logic [7:0] kbd_code = 0;
    logic [15:0] reg_wdata = 0, reg_rdata;
    int n_cmp = 0, n_err = 0;
    logic [15:0] mq[$];
    bit m_ext, m_rel, m_ovf, m_ien;

    ps2_kbd_queue #(.DEPTH(DEPTH), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .kbd_code(kbd_code), .kbd_irq(kbd_irq),
        .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq)
    );
    always #5 clk = ~clk;

    function automatic logic [15:0] m_status();
        return {8'(mq.size()), 4'b0, m_ien, m_ovf, mq.size() == DEPTH, mq.size() != 0};
    endfunction
    function automatic void m_push(input bit rel, input bit ext, input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back({1'b1, 5'b0, ext, rel, b});
        else m_ovf = 1;
    endfunction
    function automatic void m_byte(input logic [7:0] b);
        if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_rel = 0; end
        else if (m_rel) begin m_push(1, m_ext, b); m_ext = 0; m_rel = 0; end
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin m_push(0, m_ext, b); m_ext = 0; end
    endfunction
    function automatic logic [15:0] m_pop();
        return mq.size() != 0 ? mq.pop_front() : 16'h0000;
    endfunction
    function automatic logic [7:0] rand_key();
        logic [7:0] b;
        do b = 8'($urandom_range(1, 254)); while (b == 8'hE0 || b == 8'hF0);
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        mq.delete(); m_ext = 0; m_rel = 0; m_ovf = 0; m_ien = 0;
    endtask
    task automatic send_byte(input logic [7:0] b, input int len);
        @(negedge clk); kbd_code = b; kbd_irq = 1;
        repeat (len) @(negedge clk);
        kbd_irq = 0;
        @(negedge clk);
        m_byte(b);
    endtask
    task automatic rd_reg(input logic a, output logic [15:0] d);
        @(negedge clk); reg_addr = a; reg_rd = 1;
        #1 d = reg_rdata;
        @(negedge clk); reg_rd = 0;
    endtask
    task automatic wr_reg(input logic a, input logic [15:0] d);
        @(negedge clk); reg_addr = a; reg_wr = 1; reg_wdata = d;
        @(negedge clk); reg_wr = 0;
        if (a) begin m_ien = d[3]; if (d[2]) m_ovf = 0; end
    endtask
    task automatic chk_data(input string name);
        logic [15:0] d, e;
        rd_reg(0, d); e = m_pop();
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL %s: got %h expected %h", name, d, e); end
    endtask
    task automatic chk_status(input string name);
        logic [15:0] d;
        rd_reg(1, d);
        n_cmp++;
        if (d !== m_status()) begin n_err++; $display("FAIL %s: got %h expected %h", name, d, m_status()); end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        chk_status("reset_status");
        chk_data("reset_data");
    endtask
    task automatic test_single();
        send_byte(8'h1C, 4);
        chk_data("single_1c");
        chk_data("single_empty");
        send_byte(8'h1C, 100);
        chk_status("long_pulse_status");
        chk_data("long_pulse_data");
        chk_data("long_pulse_empty");
    endtask
    task automatic test_prefix();
        send_byte(8'hE0, 2); send_byte(8'hF0, 3); send_byte(8'h75, 1);
        chk_data("ext_brk_75");
        send_byte(8'hF0, 2); send_byte(8'h1C, 2);
        chk_data("brk_1c");
        send_byte(8'hE0, 1); send_byte(8'h75, 2);
        chk_data("ext_75");
        send_byte(8'hE0, 2); send_byte(8'hFF, 2);
        chk_status("discard_no_push");
        send_byte(8'h1C, 2);
        chk_data("after_discard");
        send_byte(8'hF0, 1); send_byte(8'hE0, 1);
        chk_data("brk_e0_code");
    endtask
    task automatic test_timeout();
        send_byte(8'hE0, 2);
        repeat ((1 << TO_W) + 16) @(negedge clk);
        m_ext = 0; m_rel = 0;
        send_byte(8'h1C, 2);
        chk_data("timeout_ext_dropped");
        send_byte(8'hE0, 2);
        repeat (10) @(negedge clk);
        send_byte(8'h75, 2);
        chk_data("short_gap_keeps_ext");
    endtask
    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) send_byte(rand_key(), $urandom_range(1, 4));
        chk_status("ovf_status");
        for (int i = 0; i < DEPTH; i++) chk_data("ovf_order");
        wr_reg(1, 16'h0004);
        chk_status("ovf_cleared");
    endtask
    task automatic test_irq();
        logic [15:0] d;
        wr_reg(1, 16'h0008);
        @(negedge clk); kbd_code = 8'h2A; kbd_irq = 1;
        @(negedge clk); kbd_irq = 0; m_byte(8'h2A);
        n_cmp++;
        if (irq !== 1'b0 || dut.reg_rdata === 16'hxxxx) begin n_err++; $display("FAIL irq_latency: got %b expected 0", irq); end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
        chk_status("irq_status");
        chk_data("irq_pop");
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", irq); end
        wr_reg(1, 16'h0000);
        send_byte(8'h3B, 2);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_disabled: got %b expected 0", irq); end
        chk_data("irq_disabled_data");
        rd_reg(0, d);
    endtask
    task automatic test_back_to_back();
        logic [15:0] d, e;
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) send_byte(rand_key(), 1);
        b = rand_key();
        @(negedge clk); kbd_code = b; kbd_irq = 1; reg_addr = 0; reg_rd = 1;
        #1 d = reg_rdata;
        @(negedge clk); reg_rd = 0; kbd_irq = 0;
        e = m_pop(); m_byte(b);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL full_pushpop_head: got %h expected %h", d, e); end
        chk_status("full_pushpop_status");
        for (int i = 0; i < DEPTH; i++) chk_data("full_pushpop_drain");
    endtask
    task automatic test_reset_mid();
        send_byte(8'hE0, 2);
        do_reset();
        send_byte(8'h1C, 2);
        chk_data("reset_mid_prefix");
        @(negedge clk); kbd_code = 8'h2A; kbd_irq = 1; rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        kbd_irq = 0;
        mq.delete(); m_ext = 0; m_rel = 0; m_ovf = 0; m_ien = 0;
        chk_status("held_across_reset");
    endtask
    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            b = r == 0 ? 8'hE0 : r == 1 ? 8'hF0 : r == 2 ? ($urandom_range(0, 1) ? 8'h00 : 8'hFF) : 8'($urandom_range(1, 254));
            send_byte(b, $urandom_range(1, 5));
            if ($urandom_range(0, 1) != 0) chk_data("rand_data");
            if (i % 10 == 9) chk_status("rand_status");
        end
        while (mq.size() != 0) chk_data("rand_drain");
        chk_data("rand_final_empty");
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_timeout();
        test_overflow();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
